// File: rtl/nes_pad_poller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : nes_pad_poller
// Description : Autonomous poller for two NES controller ports. Drives the
//               shared latch / clock strobes of the pads' 4021 shift
//               registers, samples both serial data lines in parallel and
//               publishes active-high button bytes plus presence flags once
//               per frame (or on demand).
// Revision    : 1.0 - initial release
// ============================================================================
module nes_pad_poller #(
    parameter int unsigned PULSE_CYC = 300,     // cycles per strobe phase
    parameter int unsigned POLL_CYC  = 833333   // cycles between poll starts
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       poll_now,
    output logic       pad_latch,
    output logic       pad_clk,
    input  logic       pad_data0,
    input  logic       pad_data1,
    output logic [7:0] buttons0,
    output logic [7:0] buttons1,
    output logic       present0,
    output logic       present1,
    output logic       valid,
    output logic       busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int unsigned c_PW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
    localparam int unsigned c_TW = (POLL_CYC  > 1) ? $clog2(POLL_CYC)  : 1;

    localparam logic [c_PW-1:0] c_PHASE_LAST = c_PW'(PULSE_CYC - 1);
    localparam logic [c_TW-1:0] c_TIMER_LAST = c_TW'(POLL_CYC - 1);
    // Bit 8 is the presence probe shifted in from the grounded serial input.
    localparam logic [3:0]      c_LAST_BIT   = 4'd8;

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_LATCH  = 3'd1;
    localparam logic [2:0] c_GAP    = 3'd2;
    localparam logic [2:0] c_CLK_LO = 3'd3;
    localparam logic [2:0] c_CLK_HI = 3'd4;
    localparam logic [2:0] c_DONE   = 3'd5;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [1:0]      r_sync0;
    logic [1:0]      r_sync1;
    logic            w_data0;
    logic            w_data1;

    logic [c_TW-1:0] r_timer;
    logic            w_expiry;
    logic            r_pending;
    logic            w_start;

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [c_PW-1:0] r_phase;
    logic [c_PW-1:0] w_phase_nxt;
    logic [3:0]      r_bit;
    logic [3:0]      w_bit_nxt;
    logic            w_phase_end;
    logic            w_sample;
    logic            w_commit;

    logic            w_latch_nxt;
    logic            w_clk_nxt;
    logic            w_busy_nxt;
    logic            w_valid_nxt;

    logic [7:0]      r_raw0;
    logic [7:0]      r_raw1;

    // ------------------------------------------------------------------------
    // Input synchronizers (pad data is asynchronous; idle/pulled-up level = 1)
    // ------------------------------------------------------------------------

    // Two-flop synchronizers for both serial data lines.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_sync0 <= 2'b11;
            r_sync1 <= 2'b11;
        end else begin
            r_sync0 <= {r_sync0[0], pad_data0};
            r_sync1 <= {r_sync1[0], pad_data1};
        end
    end

    assign w_data0 = r_sync0[1];
    assign w_data1 = r_sync1[1];

    // ------------------------------------------------------------------------
    // Poll timer and request handling
    // ------------------------------------------------------------------------
    assign w_expiry = (r_timer == c_TIMER_LAST);
    assign w_start  = (r_state == c_IDLE) && (w_expiry || poll_now || r_pending);

    // Free-running frame timer; an immediate request in IDLE re-phases it so
    // the next periodic poll lands one full period after this one.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            // Loaded with the terminal count so the first poll starts on the
            // first edge after reset is released.
            r_timer <= c_TIMER_LAST;
        end else if (w_expiry || ((r_state == c_IDLE) && poll_now)) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // Remember any request that arrives while a poll is running; however
    // many arrive, they collapse into a single follow-up poll.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_pending <= 1'b0;
        end else if (r_state == c_IDLE) begin
            if (w_start) begin
                r_pending <= 1'b0;
            end
        end else if (poll_now || w_expiry) begin
            r_pending <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Strobe sequencer
    // ------------------------------------------------------------------------
    assign w_phase_end = (r_phase == c_PHASE_LAST);

    // Sample points: last GAP cycle (bit 0) and last CLK_HI cycle (bits 1..8).
    assign w_sample = w_phase_end && ((r_state == c_GAP) || (r_state == c_CLK_HI));
    // The final sample is the presence probe; results are committed with it.
    assign w_commit = w_phase_end && (r_state == c_CLK_HI) && (r_bit == c_LAST_BIT);

    // State, phase counter and bit index registers.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_phase <= '0;
            r_bit   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_bit   <= w_bit_nxt;
        end
    end

    // Next-state logic: every timed state lasts PULSE_CYC cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit;
        case (r_state)
            c_IDLE: begin
                w_bit_nxt = '0;
                if (w_start) begin
                    w_state_nxt = c_LATCH;
                end
            end
            c_LATCH: begin
                if (w_phase_end) begin
                    w_state_nxt = c_GAP;
                end
            end
            c_GAP: begin
                if (w_phase_end) begin
                    w_state_nxt = c_CLK_LO;
                    w_bit_nxt   = r_bit + 4'd1;
                end
            end
            c_CLK_LO: begin
                if (w_phase_end) begin
                    w_state_nxt = c_CLK_HI;
                end
            end
            c_CLK_HI: begin
                if (w_phase_end) begin
                    if (r_bit == c_LAST_BIT) begin
                        w_state_nxt = c_DONE;
                    end else begin
                        w_state_nxt = c_CLK_LO;
                        w_bit_nxt   = r_bit + 4'd1;
                    end
                end
            end
            c_DONE: begin
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase

        // Phase restarts at every state change and rests at zero when idle.
        if ((w_state_nxt != r_state) || (r_state == c_IDLE) || (r_state == c_DONE)) begin
            w_phase_nxt = '0;
        end else begin
            w_phase_nxt = r_phase + 1'b1;
        end
    end

    // Output decode from the upcoming state, so the strobes change on the
    // same edge as the state and leave the block straight from flops.
    always_comb begin
        w_latch_nxt = (w_state_nxt == c_LATCH);
        w_clk_nxt   = (w_state_nxt != c_CLK_LO);
        w_busy_nxt  = (w_state_nxt == c_LATCH)  || (w_state_nxt == c_GAP) ||
                      (w_state_nxt == c_CLK_LO) || (w_state_nxt == c_CLK_HI);
        w_valid_nxt = (w_state_nxt == c_DONE);
    end

    // Registered strobe and status outputs.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pad_latch <= 1'b0;
            pad_clk   <= 1'b1;
            busy      <= 1'b0;
            valid     <= 1'b0;
        end else begin
            pad_latch <= w_latch_nxt;
            pad_clk   <= w_clk_nxt;
            busy      <= w_busy_nxt;
            valid     <= w_valid_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Data capture
    // ------------------------------------------------------------------------

    // Shift in bits 0..7 LSB-first; on the presence sample publish both pads
    // atomically (data is active-low, outputs are active-high).
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_raw0   <= '1;
            r_raw1   <= '1;
            buttons0 <= 8'h00;
            buttons1 <= 8'h00;
            present0 <= 1'b0;
            present1 <= 1'b0;
        end else if (w_commit) begin
            buttons0 <= ~r_raw0;
            buttons1 <= ~r_raw1;
            present0 <= ~w_data0;
            present1 <= ~w_data1;
        end else if (w_sample) begin
            r_raw0 <= {w_data0, r_raw0[7:1]};
            r_raw1 <= {w_data1, r_raw1[7:1]};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nes_pad_poller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_nes_pad_poller
// Description : Scoreboard bench for nes_pad_poller with two 4021 pad models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nes_pad_poller;

    localparam int c_PULSE = 4;
    localparam int c_POLL  = 200;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       poll_now = 1'b0;
    logic       pad_latch;
    logic       pad_clk;
    logic       pad_data0;
    logic       pad_data1;
    logic [7:0] buttons0;
    logic [7:0] buttons1;
    logic       present0;
    logic       present1;
    logic       valid;
    logic       busy;

    nes_pad_poller #(
        .PULSE_CYC (c_PULSE),
        .POLL_CYC  (c_POLL)
    ) dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .poll_now  (poll_now),
        .pad_latch (pad_latch),
        .pad_clk   (pad_clk),
        .pad_data0 (pad_data0),
        .pad_data1 (pad_data1),
        .buttons0  (buttons0),
        .buttons1  (buttons1),
        .present0  (present0),
        .present1  (present1),
        .valid     (valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------------
    // Pad models: 4021 loads while latch is high, shifts on pad_clk rise,
    // serial-in grounded; pressed button reads 0. Unplugged port reads 1.
    // ------------------------------------------------------------------------
    logic [7:0] btn0  = 8'h00;
    logic [7:0] btn1  = 8'h00;
    logic       plug0 = 1'b1;
    logic       plug1 = 1'b1;
    logic [7:0] sr0   = 8'hFF;
    logic [7:0] sr1   = 8'hFF;

    always @(posedge pad_clk or posedge pad_latch) begin
        if (pad_latch) sr0 <= ~btn0;
        else           sr0 <= {1'b0, sr0[7:1]};
    end

    always @(posedge pad_clk or posedge pad_latch) begin
        if (pad_latch) sr1 <= ~btn1;
        else           sr1 <= {1'b0, sr1[7:1]};
    end

    assign pad_data0 = plug0 ? sr0[0] : 1'b1;
    assign pad_data1 = plug1 ? sr1[0] : 1'b1;

    // ------------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------------
    int errors = 0;
    int checks = 0;
    logic [17:0] exp_q[$];   // {buttons0, present0, buttons1, present1}

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
    endtask

    function automatic logic [17:0] pack(input logic [7:0] b0, input logic p0,
                                         input logic [7:0] b1, input logic p1);
        return {b0, p0, b1, p1};
    endfunction

    // ------------------------------------------------------------------------
    // Monitor: strobe timing per poll and scoreboard pop on every valid
    // ------------------------------------------------------------------------
    initial begin
        int          start_cyc  = 0;
        bit          have_start = 0;
        bit          prev_busy  = 0;
        int          busy_cnt   = 0;
        int          latch_run  = 0;
        int          latch_tot  = 0;
        int          low_run    = 0;
        int          falls      = 0;
        logic [17:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                have_start = 0;
                latch_run  = 0;
                low_run    = 0;
            end else begin
                if (busy && !prev_busy) begin
                    start_cyc  = cyc;
                    have_start = 1;
                    busy_cnt   = 0;
                    latch_tot  = 0;
                    falls      = 0;
                end
                if (busy) busy_cnt++;
                if (pad_latch) begin
                    latch_run++;
                    latch_tot++;
                end else if (latch_run != 0) begin
                    chk("latch_width", latch_run, c_PULSE);
                    latch_run = 0;
                end
                if (!pad_clk) begin
                    low_run++;
                end else if (low_run != 0) begin
                    chk("clk_low_width", low_run, c_PULSE);
                    falls++;
                    low_run = 0;
                end
                if (valid) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_valid");
                    end else begin
                        e = exp_q.pop_front();
                        chk("buttons0", int'(buttons0), int'(e[17:10]));
                        chk("present0", int'(present0), int'(e[9]));
                        chk("buttons1", int'(buttons1), int'(e[8:1]));
                        chk("present1", int'(present1), int'(e[0]));
                    end
                    if (have_start) begin
                        chk("valid_cycle", cyc - start_cyc + 1, 18 * c_PULSE + 1);
                        chk("busy_cycles", busy_cnt, 18 * c_PULSE);
                        chk("clk_pulses", falls, 8);
                        chk("latch_cycles", latch_tot, c_PULSE);
                        have_start = 0;
                    end else begin
                        fail_now("valid_without_start");
                    end
                end
            end
            prev_busy = busy;
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (bounded waits)
    // ------------------------------------------------------------------------
    task automatic wait_valid(input int bound, output int at);
        at = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (valid) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) fail_now("valid_timeout");
    endtask

    task automatic wait_busy(input int bound);
        bit seen;
        seen = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (busy) begin
                seen = 1;
                break;
            end
        end
        if (!seen) fail_now("busy_timeout");
    endtask

    task automatic pulse_poll_now();
        poll_now = 1'b1;
        @(negedge clk);
        poll_now = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------------
    initial begin
        int r, v0, v1, v2, v3, v4, v5, v6, v7, v8, v9, v10;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_pad_latch", int'(pad_latch), 0);
        chk("rst_pad_clk",   int'(pad_clk),   1);
        chk("rst_buttons0",  int'(buttons0),  0);
        chk("rst_buttons1",  int'(buttons1),  0);
        chk("rst_present0",  int'(present0),  0);
        chk("rst_present1",  int'(present1),  0);
        chk("rst_valid",     int'(valid),     0);
        chk("rst_busy",      int'(busy),      0);

        // Pad0 A+Start, pad1 connected idle; first poll on first edge
        btn0 = 8'h09; btn1 = 8'h00; plug0 = 1'b1; plug1 = 1'b1;
        exp_q.push_back(pack(8'h09, 1'b1, 8'h00, 1'b1));
        reset = 1'b0;
        r = cyc;
        wait_valid(100, v0);
        chk("first_valid_latency", v0 - r, 73);

        // Pad1 unplugged, pad0 Left; periodic polls 200 cycles apart
        btn0 = 8'h40; plug1 = 1'b0;
        exp_q.push_back(pack(8'h40, 1'b1, 8'h00, 1'b0));
        wait_valid(250, v1);
        chk("period_1", v1 - v0, c_POLL);
        exp_q.push_back(pack(8'h40, 1'b1, 8'h00, 1'b0));
        wait_valid(250, v2);
        chk("period_2", v2 - v1, c_POLL);

        // Two poll_now pulses during a poll -> exactly one extra poll
        btn0 = 8'h82; btn1 = 8'h11; plug1 = 1'b1;
        exp_q.push_back(pack(8'h82, 1'b1, 8'h11, 1'b1));
        exp_q.push_back(pack(8'h82, 1'b1, 8'h11, 1'b1));
        wait_busy(250);
        repeat (5) @(negedge clk);
        pulse_poll_now();
        repeat (10) @(negedge clk);
        pulse_poll_now();
        wait_valid(100, v3);
        wait_valid(100, v4);
        chk("pending_restart", v4 - v3, 74);
        exp_q.push_back(pack(8'h82, 1'b1, 8'h11, 1'b1));
        wait_valid(300, v5);
        chk("period_after_pending", v5 - v3, c_POLL);

        // poll_now on the timer-expiry cycle -> single poll
        repeat (127) @(negedge clk);
        pulse_poll_now();
        exp_q.push_back(pack(8'h82, 1'b1, 8'h11, 1'b1));
        wait_valid(250, v6);
        chk("expiry_and_request", v6 - v5, c_POLL);
        exp_q.push_back(pack(8'h82, 1'b1, 8'h11, 1'b1));
        wait_valid(250, v7);
        chk("no_extra_poll", v7 - v6, c_POLL);

        // poll_now in IDLE starts a poll and re-phases the timer
        repeat (10) @(negedge clk);
        pulse_poll_now();
        exp_q.push_back(pack(8'h82, 1'b1, 8'h11, 1'b1));
        wait_valid(250, v8);
        chk("idle_request_latency", v8 - v7, 83);
        exp_q.push_back(pack(8'h82, 1'b1, 8'h11, 1'b1));
        wait_valid(250, v9);
        chk("timer_reloaded", v9 - v8, c_POLL);

        // Reset during bit 3 abandons the poll immediately
        btn0 = 8'h24; btn1 = 8'hC3;
        wait_busy(250);
        repeat (26) @(negedge clk);
        chk("bit3_pad_clk_low", int'(pad_clk), 0);
        chk("bit3_busy",        int'(busy),    1);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_pad_latch", int'(pad_latch), 0);
        chk("midrst_pad_clk",   int'(pad_clk),   1);
        chk("midrst_buttons0",  int'(buttons0),  0);
        chk("midrst_buttons1",  int'(buttons1),  0);
        chk("midrst_present0",  int'(present0),  0);
        chk("midrst_present1",  int'(present1),  0);
        chk("midrst_busy",      int'(busy),      0);
        chk("midrst_valid",     int'(valid),     0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        r = cyc;
        exp_q.push_back(pack(8'h24, 1'b1, 8'hC3, 1'b1));
        wait_valid(100, v10);
        chk("post_reset_latency", v10 - r, 73);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
